gray_sdram_writer: RTL and testbench

GRAY_SDRAM_WRITER -- requirements
Module: gray_sdram_writer

---
 rtl/gray_pkg.sv | 23 ++
 rtl/rgb_to_luma.sv | 20 ++
 rtl/gray_sdram_writer.sv | 102 ++++++++++
 tb/tb_gray_sdram_writer.sv | 291 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/gray_pkg.sv
// Shared definitions for the grayscale SDRAM frame writer: state codes,
// luma weights and default frame geometry.
package gray_pkg;

    typedef enum logic [3:0] {
        ST_IDLE   = 4'd0,
        ST_ACC_HI = 4'd1,
        ST_ACC_LO = 4'd2,
        ST_WRITE  = 4'd3,
        ST_DONE   = 4'd4
    } state_t;

    // ITU-R 601 style weights scaled by 256; they sum to exactly 256, so
    // white maps to 255 without saturation.
    localparam logic [15:0] LUMA_R_COEF = 16'd77;
    localparam logic [15:0] LUMA_G_COEF = 16'd150;
    localparam logic [15:0] LUMA_B_COEF = 16'd29;

    // 512x512 pixels, two 8-bit pixels per 16-bit SDRAM word.
    localparam int unsigned DEFAULT_NUM_WORDS = 131072;
    localparam logic [31:0] DEFAULT_BASE_ADDR = 32'd0;

endpackage

// File: rtl/rgb_to_luma.sv
// Combinational RGB888 to 8-bit luma conversion.
module rgb_to_luma
    import gray_pkg::*;
(
    input  logic [23:0] rgb,
    output logic [7:0]  luma
);

    // Weighted sum in 16 bits; the upper byte is the luma value.
    function automatic logic [7:0] weigh_luma(input logic [23:0] px);
        logic [15:0] sum;
        sum = LUMA_R_COEF * 16'(px[23:16])
            + LUMA_G_COEF * 16'(px[15:8])
            + LUMA_B_COEF * 16'(px[7:0]);
        return sum[15:8];
    endfunction

    assign luma = weigh_luma(rgb);

endmodule

// File: rtl/gray_sdram_writer.sv
// Converts a stream of RGB pixels to luma, packs two pixels per 16-bit word
// and writes one frame of words to SDRAM over Avalon-MM.
module gray_sdram_writer
    import gray_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR = DEFAULT_BASE_ADDR,
    parameter int unsigned NUM_WORDS = DEFAULT_NUM_WORDS
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        startSig,
    output logic        doneSig,
    input  logic        pix_valid,
    output logic        pix_ready,
    input  logic [23:0] pix_rgb,
    output logic [31:0] address,
    output logic        chipselect,
    output logic        write_n,
    output logic [1:0]  byteenable,
    output logic [15:0] writedata,
    input  logic        waitrequest,
    output logic [3:0]  s
);

    localparam logic [31:0] LAST_CNT = 32'(NUM_WORDS - 1);

    state_t      state;
    state_t      state_nxt;
    logic [31:0] word_cnt;
    logic [7:0]  luma;
    logic        pix_xfer;
    logic        last_word;

    rgb_to_luma u_luma (
        .rgb  (pix_rgb),
        .luma (luma)
    );

    assign pix_xfer  = pix_valid & pix_ready;
    assign last_word = (word_cnt == LAST_CNT);
    assign s         = state;

    // State register.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic: one state per cycle; a frame only ends by count or reset.
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:   if (startSig)     state_nxt = ST_ACC_HI;
            ST_ACC_HI: if (pix_xfer)     state_nxt = ST_ACC_LO;
            ST_ACC_LO: if (pix_xfer)     state_nxt = ST_WRITE;
            ST_WRITE:  if (!waitrequest) state_nxt = last_word ? ST_DONE : ST_ACC_HI;
            ST_DONE:   if (!startSig)    state_nxt = ST_IDLE;
            default:                     state_nxt = ST_IDLE;
        endcase
    end

    // Output decode from the current state; the bus is idle outside WRITE.
    always_comb begin
        pix_ready  = 1'b0;
        chipselect = 1'b0;
        write_n    = 1'b1;
        byteenable = 2'b00;
        doneSig    = 1'b0;
        address    = 32'd0;
        case (state)
            ST_ACC_HI, ST_ACC_LO: pix_ready = 1'b1;
            ST_WRITE: begin
                chipselect = 1'b1;
                write_n    = 1'b0;
                byteenable = 2'b11;
                address    = BASE_ADDR + word_cnt;
            end
            ST_DONE:  doneSig = 1'b1;
            default:  ;
        endcase
    end

    // Word assembly and write counter; both hold while the slave stalls.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            writedata <= 16'd0;
            word_cnt  <= 32'd0;
        end else begin
            case (state)
                ST_IDLE:   word_cnt <= 32'd0;
                ST_ACC_HI: if (pix_xfer) writedata[15:8] <= luma;
                ST_ACC_LO: if (pix_xfer) writedata[7:0]  <= luma;
                ST_WRITE:  if (!waitrequest) word_cnt <= word_cnt + 32'd1;
                default:   ;
            endcase
        end
    end

endmodule

// File: tb/tb_gray_sdram_writer.sv
// Testbench for gray_sdram_writer: directed scenarios plus randomized frames
// checked against a pixel-pair luma reference model.
module tb_gray_sdram_writer;

    localparam logic [31:0] BASE = 32'h100;
    localparam int          NW   = 5;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        startSig;
    logic        doneSig;
    logic        pix_valid;
    logic        pix_ready;
    logic [23:0] pix_rgb;
    logic [31:0] address;
    logic        chipselect;
    logic        write_n;
    logic [1:0]  byteenable;
    logic [15:0] writedata;
    logic        waitrequest;
    logic [3:0]  s;

    int errors = 0;
    int checks = 0;

    logic [31:0] wa_q[$];
    logic [15:0] wd_q[$];
    logic [23:0] acc_q[$];

    gray_sdram_writer #(.BASE_ADDR(BASE), .NUM_WORDS(NW)) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .startSig    (startSig),
        .doneSig     (doneSig),
        .pix_valid   (pix_valid),
        .pix_ready   (pix_ready),
        .pix_rgb     (pix_rgb),
        .address     (address),
        .chipselect  (chipselect),
        .write_n     (write_n),
        .byteenable  (byteenable),
        .writedata   (writedata),
        .waitrequest (waitrequest),
        .s           (s)
    );

    always #5 clk = ~clk;

    // Record every completed bus write.
    always @(posedge clk) begin
        if (reset_n === 1'b1 && chipselect === 1'b1 && write_n === 1'b0 && waitrequest === 1'b0) begin
            wa_q.push_back(address);
            wd_q.push_back(writedata);
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [7:0] ref_luma(input logic [23:0] p);
        int r, g, b;
        r = int'(p[23:16]);
        g = int'(p[15:8]);
        b = int'(p[7:0]);
        return 8'((77 * r + 150 * g + 29 * b) / 256);
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset(input int n);
        reset_n     = 1'b0;
        startSig    = 1'b0;
        pix_valid   = 1'b0;
        waitrequest = 1'b0;
        pix_rgb     = 24'd0;
        repeat (n) step();
        reset_n = 1'b1;
    endtask

    // Drive one frame with random valid/stall patterns; remembers accepted pixels.
    task automatic run_frame(input int valid_pct, input int wait_pct, input int n_fixed,
                             output bit timed_out);
        logic [23:0] fixed [4];
        logic [23:0] cur;
        int idx;
        fixed = '{24'hFFFFFF, 24'h000000, 24'hFF0000, 24'h0000FF};
        acc_q.delete();
        wa_q.delete();
        wd_q.delete();
        idx = 0;
        cur = (n_fixed > 0) ? fixed[0] : 24'($urandom);
        startSig  = 1'b1;
        timed_out = 1'b1;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            pix_rgb     = cur;
            pix_valid   = (int'($urandom_range(99)) < valid_pct);
            waitrequest = (int'($urandom_range(99)) < wait_pct);
            @(posedge clk);
            if (pix_valid && pix_ready) begin
                acc_q.push_back(cur);
                idx++;
                cur = (idx < n_fixed) ? fixed[idx] : 24'($urandom);
            end
            #1;
            if (doneSig === 1'b1) begin
                timed_out = 1'b0;
                break;
            end
        end
        pix_valid   = 1'b0;
        waitrequest = 1'b0;
    endtask

    task automatic test_reset();
        apply_reset(2);
        checks++; if (s !== 4'd0) begin errors++; $display("FAIL reset_s: got %0d want 0", s); end
        checks++; if (doneSig !== 1'b0) begin errors++; $display("FAIL reset_done: got %b want 0", doneSig); end
        checks++; if (pix_ready !== 1'b0) begin errors++; $display("FAIL reset_ready: got %b want 0", pix_ready); end
        checks++; if (chipselect !== 1'b0) begin errors++; $display("FAIL reset_cs: got %b want 0", chipselect); end
        checks++; if (write_n !== 1'b1) begin errors++; $display("FAIL reset_write_n: got %b want 1", write_n); end
        checks++; if (byteenable !== 2'b00) begin errors++; $display("FAIL reset_be: got %b want 00", byteenable); end
        checks++; if (address !== 32'd0) begin errors++; $display("FAIL reset_addr: got %h want 0", address); end
        checks++; if (writedata !== 16'd0) begin errors++; $display("FAIL reset_wdata: got %h want 0", writedata); end
    endtask

    task automatic test_known_pixels();
        bit to;
        run_frame(100, 0, 4, to);
        checks++; if (to) begin errors++; $display("FAIL known_timeout: doneSig got 0 want 1"); end
        checks++; if (wa_q.size() !== NW) begin errors++; $display("FAIL known_count: got %0d want %0d", wa_q.size(), NW); end
        checks++; if (acc_q.size() !== 2 * NW) begin errors++; $display("FAIL known_pixels: got %0d want %0d", acc_q.size(), 2 * NW); end
        if (wa_q.size() >= 2) begin
            checks++; if (wa_q[0] !== 32'h100 || wd_q[0] !== 16'hFF00) begin errors++;
                $display("FAIL known_word0: got %h<=%h want 100<=ff00", wa_q[0], wd_q[0]); end
            checks++; if (wa_q[1] !== 32'h101 || wd_q[1] !== 16'h4C1C) begin errors++;
                $display("FAIL known_word1: got %h<=%h want 101<=4c1c", wa_q[1], wd_q[1]); end
        end
        for (int k = 0; k < wa_q.size() && 2 * k + 1 < acc_q.size(); k++) begin
            checks++;
            if (wa_q[k] !== BASE + 32'(k) || wd_q[k] !== {ref_luma(acc_q[2*k]), ref_luma(acc_q[2*k+1])}) begin
                errors++;
                $display("FAIL known_frame[%0d]: got %h<=%h want %h<=%h", k, wa_q[k], wd_q[k],
                         BASE + 32'(k), {ref_luma(acc_q[2*k]), ref_luma(acc_q[2*k+1])});
            end
        end
        checks++; if (doneSig !== 1'b1 || s !== 4'd4) begin errors++;
            $display("FAIL known_done: got done=%b s=%0d want done=1 s=4", doneSig, s); end
    endtask

    task automatic test_done_hold();
        startSig = 1'b1;
        for (int i = 0; i < 10; i++) begin
            step();
            checks++; if (doneSig !== 1'b1 || s !== 4'd4) begin errors++;
                $display("FAIL done_hold[%0d]: got done=%b s=%0d want done=1 s=4", i, doneSig, s); end
        end
        startSig = 1'b0;
        step();
        checks++; if (doneSig !== 1'b0 || s !== 4'd0) begin errors++;
            $display("FAIL done_release: got done=%b s=%0d want done=0 s=0", doneSig, s); end
    endtask

    task automatic test_stall();
        logic [23:0] pa, pb;
        logic [15:0] want;
        pa = 24'($urandom);
        pb = 24'($urandom);
        want = {ref_luma(pa), ref_luma(pb)};
        wa_q.delete();
        wd_q.delete();
        startSig    = 1'b1;
        waitrequest = 1'b1;
        pix_valid   = 1'b1;
        pix_rgb     = pa;
        step();
        step();
        pix_rgb = pb;
        step();
        pix_valid = 1'b0;
        for (int i = 0; i < 5; i++) begin
            checks++;
            if (write_n !== 1'b0 || address !== BASE || writedata !== want || byteenable !== 2'b11) begin
                errors++;
                $display("FAIL stall[%0d]: got wn=%b a=%h d=%h be=%b want wn=0 a=%h d=%h be=11",
                         i, write_n, address, writedata, byteenable, BASE, want);
            end
            step();
        end
        checks++; if (wa_q.size() !== 0) begin errors++; $display("FAIL stall_early: got %0d writes want 0", wa_q.size()); end
        waitrequest = 1'b0;
        step();
        checks++; if (write_n !== 1'b1 || pix_ready !== 1'b1) begin errors++;
            $display("FAIL stall_release: got wn=%b ready=%b want wn=1 ready=1", write_n, pix_ready); end
        checks++; if (wa_q.size() !== 1) begin errors++; $display("FAIL stall_writes: got %0d want 1", wa_q.size()); end
        pix_valid = 1'b1;
        pix_rgb   = 24'($urandom);
        step();
        pix_rgb   = 24'($urandom);
        step();
        pix_valid = 1'b0;
        checks++; if (write_n !== 1'b0 || address !== BASE + 32'd1) begin errors++;
            $display("FAIL stall_next_addr: got wn=%b a=%h want wn=0 a=%h", write_n, address, BASE + 32'd1); end
    endtask

    task automatic test_valid_toggle();
        logic [23:0] pa, pb;
        bit v [4];
        v  = '{1'b1, 1'b0, 1'b0, 1'b1};
        pa = 24'($urandom);
        pb = 24'($urandom);
        apply_reset(2);
        startSig = 1'b1;
        step();
        for (int i = 0; i < 4; i++) begin
            pix_valid = v[i];
            pix_rgb   = (i == 0) ? pa : (i == 3) ? pb : 24'($urandom);
            checks++; if (pix_ready !== 1'b1 || write_n !== 1'b1) begin errors++;
                $display("FAIL toggle[%0d]: got ready=%b wn=%b want ready=1 wn=1", i, pix_ready, write_n); end
            step();
        end
        pix_valid = 1'b0;
        checks++;
        if (write_n !== 1'b0 || writedata !== {ref_luma(pa), ref_luma(pb)} || address !== BASE) begin
            errors++;
            $display("FAIL toggle_write: got wn=%b a=%h d=%h want wn=0 a=%h d=%h", write_n, address,
                     writedata, BASE, {ref_luma(pa), ref_luma(pb)});
        end
    endtask

    task automatic test_reset_midframe();
        bit to;
        apply_reset(2);
        wa_q.delete();
        wd_q.delete();
        startSig = 1'b1;
        for (int cyc = 0; cyc < 200 && wa_q.size() < 3; cyc++) begin
            pix_valid = 1'b1;
            pix_rgb   = 24'($urandom);
            step();
        end
        checks++; if (wa_q.size() !== 3) begin errors++; $display("FAIL mid_prefill: got %0d writes want 3", wa_q.size()); end
        waitrequest = 1'b1;
        pix_valid   = 1'b1;
        step();
        step();
        pix_valid = 1'b0;
        step();
        checks++; if (write_n !== 1'b0 || address !== BASE + 32'd3) begin errors++;
            $display("FAIL mid_stalled: got wn=%b a=%h want wn=0 a=%h", write_n, address, BASE + 32'd3); end
        reset_n  = 1'b0;
        startSig = 1'b0;
        step();
        reset_n     = 1'b1;
        waitrequest = 1'b0;
        checks++; if (s !== 4'd0 || write_n !== 1'b1 || chipselect !== 1'b0) begin errors++;
            $display("FAIL mid_reset: got s=%0d wn=%b cs=%b want s=0 wn=1 cs=0", s, write_n, chipselect); end
        checks++; if (wa_q.size() !== 3) begin errors++; $display("FAIL mid_dropped: got %0d writes want 3", wa_q.size()); end
        run_frame(70, 30, 0, to);
        checks++; if (to) begin errors++; $display("FAIL mid_timeout: doneSig got 0 want 1"); end
        checks++; if (wa_q.size() !== NW) begin errors++; $display("FAIL mid_count: got %0d want %0d", wa_q.size(), NW); end
        if (wa_q.size() > 0) begin
            checks++; if (wa_q[0] !== BASE) begin errors++; $display("FAIL mid_first_addr: got %h want %h", wa_q[0], BASE); end
        end
        for (int k = 0; k < wa_q.size() && 2 * k + 1 < acc_q.size(); k++) begin
            checks++;
            if (wa_q[k] !== BASE + 32'(k) || wd_q[k] !== {ref_luma(acc_q[2*k]), ref_luma(acc_q[2*k+1])}) begin
                errors++;
                $display("FAIL mid_frame[%0d]: got %h<=%h want %h<=%h", k, wa_q[k], wd_q[k],
                         BASE + 32'(k), {ref_luma(acc_q[2*k]), ref_luma(acc_q[2*k+1])});
            end
        end
    endtask

    initial begin
        test_reset();
        test_known_pixels();
        test_done_hold();
        test_stall();
        test_valid_toggle();
        test_reset_midframe();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
